// File: rtl/uart_pkg.sv
// Shared types and frame constants for the uart transceiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  // Sized for the largest legal CLKS_PER_BIT (65535).
  localparam int CNT_W      = $clog2(65535 + 1);

  typedef enum logic {
    TX_IDLE,
    TX_TRANSMITTING
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: optional RX synchronizer (UART_RX_SYNC_EN), centre-sampling FSM, rdy flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clr_rdy,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_in;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end
  assign rx_in = sync[1];
`else
  assign rx_in = rx;
`endif

  rx_state_t state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic bit_end, start_det, sample, reload, set_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    sample    = 1'b0;
    reload    = 1'b0;
    set_rdy   = 1'b0;
    bit_end   = (baud_cnt == '0);
    case (state)
      RX_IDLE:  if (!rx_in) begin
        state_nxt = RX_START;
        start_det = 1'b1;
      end
      // Line must still be low at mid start bit, otherwise it was a glitch.
      RX_START: if (bit_end) begin
        state_nxt = rx_in ? RX_IDLE : RX_DATA;
        reload    = 1'b1;
      end
      RX_DATA:  if (bit_end) begin
        sample = 1'b1;
        reload = 1'b1;
        if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
      end
      RX_STOP:  if (bit_end) begin
        state_nxt = RX_IDLE;
        set_rdy   = rx_in;
      end
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      if (start_det) begin
        baud_cnt <= HALF_LAST;
        bit_cnt  <= '0;
      end else if (reload) begin
        baud_cnt <= BIT_LAST;
      end else if (state != RX_IDLE) begin
        baud_cnt <= baud_cnt - CNT_W'(1);
      end
      if (sample) begin
        shift   <= {rx_in, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (set_rdy) rx_data <= shift;
      // A completed byte beats a simultaneous clear.
      if (set_rdy)                   rdy <= 1'b1;
      else if (clr_rdy || start_det) rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx receiver.
// Define UART_RX_SYNC_EN to add a two-flop synchronizer on RX.
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 clr_rdy,
  output logic                 TX,
  output logic                 tx_done,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t state, state_nxt;
  logic [CNT_W-1:0]      baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic accept, bit_end, frame_end;

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_end = 1'b0;
    bit_end   = (baud_cnt == '0);
    case (state)
      TX_IDLE: if (trmt) begin
        accept    = 1'b1;
        state_nxt = TX_TRANSMITTING;
      end
      TX_TRANSMITTING: if (bit_end && bit_cnt == 4'(FRAME_BITS - 1)) begin
        frame_end = 1'b1;
        state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Shift register holds the whole frame {stop, data, start}; bit 0 is on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_done  <= 1'b0;
    end else if (accept) begin
      shift    <= {1'b1, tx_data, 1'b0};
      baud_cnt <= BIT_LAST;
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
    end else if (state == TX_TRANSMITTING) begin
      if (frame_end) begin
        tx_done <= 1'b1;
      end else if (bit_end) begin
        shift    <= {1'b1, shift[FRAME_BITS-1:1]};
        bit_cnt  <= bit_cnt + 4'd1;
        baud_cnt <= BIT_LAST;
      end else begin
        baud_cnt <= baud_cnt - CNT_W'(1);
      end
    end
  end

  assign TX = (state == TX_TRANSMITTING) ? shift[0] : 1'b1;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx     (RX),
    .clr_rdy(clr_rdy),
    .rdy    (rdy),
    .rx_data(rx_data)
  );

endmodule

// File: tb/tb_uart.sv
// Directed loopback bench for uart at CLKS_PER_BIT=16.
module tb_uart;

  localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
  localparam int EXP_RDY = 155;
`else
  localparam int EXP_RDY = 153;
`endif

  logic clk = 1'b0, rst = 1'b1, trmt = 1'b0, clr_rdy = 1'b0;
  logic ext_sel = 1'b0, ext_rx = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic TX, tx_done, rdy, rx_line;
  logic [7:0] rx_data;
  int vectors = 0, miscompares = 0;

  assign rx_line = ext_sel ? ext_rx : TX;
  always #5 clk = ~clk;

  uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .RX     (rx_line),
    .trmt   (trmt),
    .tx_data(tx_data),
    .clr_rdy(clr_rdy),
    .TX     (TX),
    .tx_done(tx_done),
    .rdy    (rdy),
    .rx_data(rx_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends d over loopback, checks each TX bit at its centre, reports when tx_done / rdy rose
  // (cycles after the accepting edge). mid_at > 0 pulses a stray trmt at that cycle.
  task automatic send_watch(input logic [7:0] d, input int mid_at,
                            output int done_at, output int rdy_at);
    logic [9:0] frame;
    logic prev_rdy;
    int cnt;
    frame = {1'b1, d, 1'b0};
    trmt = 1'b1;
    tx_data = d;
    tick();
    trmt = 1'b0;
    check("tx_done_clear", tx_done, 1'b0);
    check("start_bit", TX, 1'b0);
    done_at = -1;
    rdy_at = -1;
    prev_rdy = rdy;
    cnt = 0;
    while (done_at < 0 && cnt < 400) begin
      tick();
      cnt++;
      if (cnt % CPB == CPB / 2 && cnt < 10 * CPB)
        check($sformatf("tx_bit%0d", cnt / CPB), TX, frame[cnt / CPB]);
      if (rdy && !prev_rdy && rdy_at < 0) rdy_at = cnt;
      prev_rdy = rdy;
      if (tx_done) done_at = cnt;
      trmt = (cnt == mid_at);
      tx_data = (cnt == mid_at) ? ~d : d;
    end
    trmt = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ext_rx = bits[i];
      repeat (CPB) tick();
    end
    ext_rx = 1'b1;
  endtask

  initial begin
    int d_at, r_at;
    #1;
    tx_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      trmt = 1'b1;
      tick();
    end
    trmt = 1'b0;
    check("rst_TX", TX, 1'b1);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);

    rst = 1'b0;
    tick();
    tick();
    check("idle_TX", TX, 1'b1);

    send_watch(8'h55, -1, d_at, r_at);
    check("f1_done_at", d_at, 160);
    check("f1_rdy_at", r_at, EXP_RDY);
    check("f1_rx_data", rx_data, 8'h55);

    send_watch(8'hAA, -1, d_at, r_at);
    check("f2_done_at", d_at, 160);
    check("f2_rdy_at", r_at, EXP_RDY);
    check("f2_rx_data", rx_data, 8'hAA);

    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
    check("clr_rdy", rdy, 1'b0);
    check("clr_rx_data", rx_data, 8'hAA);

    ext_sel = 1'b1;
    ext_rx = 1'b1;
    repeat (2) tick();
    ext_rx = 1'b0;
    repeat (3) tick();
    ext_rx = 1'b1;
    repeat (200) tick();
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_rx_data", rx_data, 8'hAA);

    drive_frame(8'h3C, 1'b0);
    repeat (40) tick();
    check("ferr_rdy", rdy, 1'b0);
    check("ferr_rx_data", rx_data, 8'hAA);

    drive_frame(8'hC3, 1'b1);
    repeat (4) tick();
    check("ext_rdy", rdy, 1'b1);
    check("ext_rx_data", rx_data, 8'hC3);

    ext_sel = 1'b0;
    tick();
    send_watch(8'h96, 50, d_at, r_at);
    check("mid_done_at", d_at, 160);
    check("mid_rdy_at", r_at, EXP_RDY);
    check("mid_rx_data", rx_data, 8'h96);
    repeat (40) tick();
    check("mid_TX_idle", TX, 1'b1);
    check("mid_tx_done", tx_done, 1'b1);

    trmt = 1'b1;
    tx_data = 8'h00;
    tick();
    trmt = 1'b0;
    repeat (40) tick();
    check("abort_pre_TX", TX, 1'b0);
    rst = 1'b1;
    tick();
    check("abort_TX", TX, 1'b1);
    check("abort_tx_done", tx_done, 1'b0);
    check("abort_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (200) tick();
    check("abort_rdy", rdy, 1'b0);
    check("abort_TX_idle", TX, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
